control_seq: RTL and testbench

CONTROL_SEQ -- requirements
Module: control_seq

---
 rtl/control_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_control_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_seq.sv
// control_seq: multi-cycle instruction sequencer for a small accumulator core.
// Walks FETCH -> DECODE -> EXEC [-> MEM [-> WB]] -> FETCH and decodes the
// datapath controls for each state. HALT and FAULT are absorbing until rst.
//
// Handshakes (level-sensitive, no back-pressure):
//   instr_valid/ir_load : in FETCH the opcode is accepted in the same cycle
//                         instr_valid is high; ir_load mirrors that acceptance.
//                         instr_valid and opcode are don't-care in other states.
//   mem_*_en/mem_ready  : in MEM the enable is held until the cycle mem_ready
//                         is seen high; that cycle completes the access.
// The current FSM state is kept in state_q for checkers to bind to.
module control_seq #(
    parameter int TIMEOUT_W = 4,
    parameter bit REG_OUTS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [4:0] opcode,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       mem_ready,
    output logic       ir_load,
    output logic [2:0] alu_mode,
    output logic       rf_write_en,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic       rf_src_sel,
    output logic       mem_read_en,
    output logic       mem_write_en,
    output logic       pc_write_en,
    output logic       busy,
    output logic       halted,
    output logic       fault
);

    // ALU mode encoding shared with the datapath; ADD is the all-zero idle value.
    localparam logic [2:0] ALU_MODE_ADD      = 3'd0;
    localparam logic [2:0] ALU_MODE_SHIFT    = 3'd1;
    localparam logic [2:0] ALU_MODE_NOT      = 3'd2;
    localparam logic [2:0] ALU_MODE_AND      = 3'd3;
    localparam logic [2:0] ALU_MODE_OR       = 3'd4;
    localparam logic [2:0] ALU_MODE_XOR      = 3'd5;
    localparam logic [2:0] ALU_MODE_BYPASS_A = 3'd6;

    // A wait gives up on the cycle the counter would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);
    localparam logic [TIMEOUT_W-1:0] TMO_ONE  = TIMEOUT_W'(1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;

    // br_en marks a conditional branch in EXEC; the flag test is applied late
    // so that the flags are sampled in EXEC itself for both output styles.
    typedef struct packed {
        logic [2:0] alu_mode;
        logic       rf_write_en;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic       rf_src_sel;
        logic       mem_read_en;
        logic       mem_write_en;
        logic       pc_write_en;
        logic       br_en;
        logic       busy;
        logic       halted;
        logic       fault;
    } ctrl_t;

    state_t               state_q, state_d;
    logic [4:0]           opcode_q, opcode_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    ctrl_t                ctrl;
    logic                 br_taken;

    function automatic ctrl_t decode_ctrl(input state_t st, input logic [4:0] op);
        ctrl_t c;
        c = '0;
        c.busy = (st != S_FETCH);
        case (st)
            S_EXEC: begin
                casez (op)
                    5'b000??, 5'b1100?: begin c.alu_mode = ALU_MODE_ADD;   c.rf_write_en = 1'b1; c.alu_b_sel = op[0]; end
                    5'b001??:           begin c.alu_mode = ALU_MODE_SHIFT; c.rf_write_en = 1'b1; c.alu_b_sel = op[0]; end
                    5'b0100?:           begin c.alu_mode = ALU_MODE_NOT;   c.rf_write_en = 1'b1; c.alu_b_sel = op[0]; end
                    5'b0101?:           begin c.alu_mode = ALU_MODE_AND;   c.rf_write_en = 1'b1; c.alu_b_sel = op[0]; end
                    5'b0110?:           begin c.alu_mode = ALU_MODE_OR;    c.rf_write_en = 1'b1; c.alu_b_sel = op[0]; end
                    5'b0111?:           begin c.alu_mode = ALU_MODE_XOR;   c.rf_write_en = 1'b1; c.alu_b_sel = op[0]; end
                    5'b1000?: begin
                        c.alu_mode    = ALU_MODE_BYPASS_A;
                        c.alu_a_sel   = op[0];
                        c.rf_write_en = 1'b1;
                    end
                    5'b1001?: c.alu_mode = ALU_MODE_BYPASS_A;
                    5'b10100: begin
                        c.alu_mode    = ALU_MODE_BYPASS_A;
                        c.pc_write_en = 1'b1;
                    end
                    5'b1101?, 5'b1110?: begin
                        c.alu_mode  = ALU_MODE_ADD;
                        c.alu_a_sel = 1'b1;
                        c.alu_b_sel = 1'b1;
                        c.br_en     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                c.alu_mode     = ALU_MODE_BYPASS_A;
                c.mem_read_en  = ~op[0];
                c.mem_write_en = op[0];
            end
            S_WB: begin
                c.rf_write_en = 1'b1;
                c.rf_src_sel  = 1'b1;
            end
            S_HALT:  c.halted = 1'b1;
            S_FAULT: c.fault  = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // Next-state, opcode latch and memory-wait timeout counter.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        tmo_d    = tmo_q;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    opcode_d = opcode;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                casez (opcode_q)
                    5'b1111?:           state_d = S_HALT;
                    5'b10101, 5'b1011?: state_d = S_FAULT;
                    default:            state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (opcode_q[4:1] == 4'b1001) begin
                    state_d = S_MEM;
                    tmo_d   = '0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = opcode_q[0] ? S_FETCH : S_WB;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                    if (tmo_q == TMO_LAST) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
    end

    // State, opcode and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            tmo_q    <= tmo_d;
        end
    end

    generate
        if (REG_OUTS) begin : g_reg_outs
            ctrl_t ctrl_q, ctrl_d;
            // Decode from the next state so the flopped controls line up with it.
            always_comb begin
                ctrl_d = decode_ctrl(state_d, opcode_d);
            end
            // Control output register, cleared by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ctrl_q <= '0;
                end else begin
                    ctrl_q <= ctrl_d;
                end
            end
            assign ctrl = ctrl_q;
        end else begin : g_comb_outs
            assign ctrl = decode_ctrl(state_q, opcode_q);
        end
    endgenerate

    // Branch condition from the latched opcode and the live EXEC-cycle flags.
    always_comb begin
        br_taken = 1'b0;
        case (opcode_q[2:0])
            3'b010:  br_taken = flag_n;
            3'b011:  br_taken = ~flag_n;
            3'b100:  br_taken = flag_z;
            3'b101:  br_taken = ~flag_z;
            default: br_taken = 1'b0;
        endcase
    end

    assign ir_load      = ~ctrl.busy & instr_valid;
    assign alu_mode     = ctrl.alu_mode;
    assign rf_write_en  = ctrl.rf_write_en;
    assign alu_a_sel    = ctrl.alu_a_sel;
    assign alu_b_sel    = ctrl.alu_b_sel;
    assign rf_src_sel   = ctrl.rf_src_sel;
    assign mem_read_en  = ctrl.mem_read_en;
    assign mem_write_en = ctrl.mem_write_en;
    assign pc_write_en  = ctrl.pc_write_en | (ctrl.br_en & br_taken);
    assign busy         = ctrl.busy;
    assign halted       = ctrl.halted;
    assign fault        = ctrl.fault;

endmodule

// File: tb/tb_control_seq.sv
// Testbench for control_seq: both output styles run side by side on the same
// stimulus and are checked cycle by cycle against instruction-level expectations.
module tb_control_seq;

    localparam int TW      = 4;
    localparam int TMO_CYC = (1 << TW) - 1;   // MEM cycles allowed without ready

    localparam logic [2:0] M_ADD = 3'd0, M_SHIFT = 3'd1, M_NOT = 3'd2, M_AND = 3'd3;
    localparam logic [2:0] M_OR  = 3'd4, M_XOR   = 3'd5, M_BYP = 3'd6;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic instr_valid = 1'b0;
    logic [4:0] opcode = '0;
    logic flag_n = 1'b0, flag_z = 1'b0, mem_ready = 1'b0;

    always #5 clk = ~clk;

    // {ir_load, alu_mode[2:0], rf_we, a_sel, b_sel, src_sel, mem_rd, mem_wr, pc_we, busy, halted, fault}
    wire [13:0] obs_r, obs_c;

    control_seq #(.TIMEOUT_W(TW), .REG_OUTS(1)) u_reg (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
        .flag_n(flag_n), .flag_z(flag_z), .mem_ready(mem_ready),
        .ir_load(obs_r[13]), .alu_mode(obs_r[12:10]), .rf_write_en(obs_r[9]),
        .alu_a_sel(obs_r[8]), .alu_b_sel(obs_r[7]), .rf_src_sel(obs_r[6]),
        .mem_read_en(obs_r[5]), .mem_write_en(obs_r[4]), .pc_write_en(obs_r[3]),
        .busy(obs_r[2]), .halted(obs_r[1]), .fault(obs_r[0])
    );

    control_seq #(.TIMEOUT_W(TW), .REG_OUTS(0)) u_comb (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
        .flag_n(flag_n), .flag_z(flag_z), .mem_ready(mem_ready),
        .ir_load(obs_c[13]), .alu_mode(obs_c[12:10]), .rf_write_en(obs_c[9]),
        .alu_a_sel(obs_c[8]), .alu_b_sel(obs_c[7]), .rf_src_sel(obs_c[6]),
        .mem_read_en(obs_c[5]), .mem_write_en(obs_c[4]), .pc_write_en(obs_c[3]),
        .busy(obs_c[2]), .halted(obs_c[1]), .fault(obs_c[0])
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [13:0] ev(input logic ir, input logic [2:0] mode,
                                       input logic rf, input logic a, input logic b,
                                       input logic src, input logic mr, input logic mw,
                                       input logic pc, input logic bsy, input logic hlt,
                                       input logic flt);
        return {ir, mode, rf, a, b, src, mr, mw, pc, bsy, hlt, flt};
    endfunction

    task automatic check(input string nm, input logic [13:0] exp);
        n_cmp++;
        if (obs_r !== exp) begin
            n_bad++;
            $display("FAIL %s (REG_OUTS=1) at %0t: got=%b want=%b", nm, $time, obs_r, exp);
        end
        n_cmp++;
        if (obs_c !== exp) begin
            n_bad++;
            $display("FAIL %s (REG_OUTS=0) at %0t: got=%b want=%b", nm, $time, obs_c, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // EXEC-cycle controls from the opcode map, using plain numeric ranges.
    function automatic logic [13:0] exec_exp(input logic [4:0] op, input logic n, input logic z);
        logic [2:0] tab [8];
        int o;
        logic [2:0] mode;
        logic rf, a, b, pc;
        tab = '{M_ADD, M_ADD, M_SHIFT, M_SHIFT, M_NOT, M_AND, M_OR, M_XOR};
        o = int'(op);
        mode = M_ADD; rf = 0; a = 0; b = 0; pc = 0;
        if (o < 16) begin
            mode = tab[o / 2]; rf = 1; b = op[0];
        end else if (o == 24 || o == 25) begin
            mode = M_ADD; rf = 1; b = op[0];
        end else if (o == 16 || o == 17) begin
            mode = M_BYP; rf = 1; a = op[0];
        end else if (o == 18 || o == 19) begin
            mode = M_BYP;
        end else if (o == 20) begin
            mode = M_BYP; pc = 1;
        end else if (o >= 26 && o <= 29) begin
            a = 1; b = 1;
            pc = (o == 26) ? n : (o == 27) ? !n : (o == 28) ? z : !z;
        end
        return ev(0, mode, rf, a, b, 0, 0, 0, pc, 1, 0, 0);
    endfunction

    // ---------------- driver tasks ----------------
    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [4:0] rop();
        return 5'($urandom_range(0, 31));
    endfunction

    // One cycle: apply inputs after the falling edge, settle, then the caller checks.
    task automatic drive(input logic iv, input logic [4:0] op, input logic n,
                         input logic z, input logic mr, input logic r);
        @(negedge clk);
        instr_valid = iv; opcode = op; flag_n = n; flag_z = z; mem_ready = mr; rst = r;
        #1;
    endtask

    task automatic do_reset();
        drive(rb(), rop(), rb(), rb(), rb(), 1'b1);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_reset", 14'd0);
    endtask

    // Runs one instruction from acceptance to its return to FETCH (or to an
    // absorbing state, reported through term). dly = mem_ready-low MEM cycles.
    task automatic run_instr(input logic [4:0] op, input logic n, input logic z,
                             input int dly, input logic [13:0] exec_e, output bit term);
        int o;
        bit done;
        logic rdy;
        o = int'(op);
        term = 1'b0;
        done = 1'b0;
        drive(1'b1, op, rb(), rb(), rb(), 1'b0);
        check("accept", ev(1, M_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(rb(), rop(), rb(), rb(), rb(), 1'b0);
        check("decode", ev(0, M_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        if (o >= 30 || (o >= 21 && o <= 23)) begin
            for (int i = 0; i < 3; i++) begin
                drive(1'b1, rop(), rb(), rb(), rb(), 1'b0);
                if (o >= 30) check("halt_absorb", ev(0, M_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
                else         check("fault_absorb", ev(0, M_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
            end
            term = 1'b1;
            return;
        end
        drive(rb(), rop(), n, z, rb(), 1'b0);
        check("exec", exec_e);
        if (o == 18 || o == 19) begin
            for (int k = 0; k < TMO_CYC; k++) begin
                rdy = (k == dly);
                drive(rb(), rop(), rb(), rb(), rdy, 1'b0);
                check("mem", ev(0, M_BYP, 0, 0, 0, 0, ~op[0], op[0], 0, 1, 0, 0));
                if (rdy) begin
                    done = 1'b1;
                    break;
                end
            end
            if (!done) begin
                for (int i = 0; i < 3; i++) begin
                    drive(1'b1, rop(), rb(), rb(), rb(), 1'b0);
                    check("timeout_fault", ev(0, M_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
                end
                term = 1'b1;
                return;
            end
            if (o == 18) begin
                drive(rb(), rop(), rb(), rb(), rb(), 1'b0);
                check("wb", ev(0, M_ADD, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0));
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [4:0]  op;
        logic        n;
        logic        z;
        int          dly;
        logic [13:0] exp;
    } vec_t;

    vec_t vt [20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit term;
        logic [4:0] op;
        logic n, z;
        int dly;

        // EXEC-cycle expectations written out by hand from the opcode map.
        vt[0]  = '{5'b00001, 0, 0, 0,  ev(0, M_ADD,   1, 0, 1, 0, 0, 0, 0, 1, 0, 0)};
        vt[1]  = '{5'b00110, 0, 0, 0,  ev(0, M_SHIFT, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        vt[2]  = '{5'b01001, 0, 0, 0,  ev(0, M_NOT,   1, 0, 1, 0, 0, 0, 0, 1, 0, 0)};
        vt[3]  = '{5'b01010, 0, 0, 0,  ev(0, M_AND,   1, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        vt[4]  = '{5'b01101, 0, 0, 0,  ev(0, M_OR,    1, 0, 1, 0, 0, 0, 0, 1, 0, 0)};
        vt[5]  = '{5'b01110, 0, 0, 0,  ev(0, M_XOR,   1, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        vt[6]  = '{5'b11001, 0, 0, 0,  ev(0, M_ADD,   1, 0, 1, 0, 0, 0, 0, 1, 0, 0)};
        vt[7]  = '{5'b10000, 0, 0, 0,  ev(0, M_BYP,   1, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        vt[8]  = '{5'b10001, 0, 0, 0,  ev(0, M_BYP,   1, 1, 0, 0, 0, 0, 0, 1, 0, 0)};
        vt[9]  = '{5'b10100, 0, 0, 0,  ev(0, M_BYP,   0, 0, 0, 0, 0, 0, 1, 1, 0, 0)};
        vt[10] = '{5'b11100, 0, 1, 0,  ev(0, M_ADD,   0, 1, 1, 0, 0, 0, 1, 1, 0, 0)};
        vt[11] = '{5'b11100, 0, 0, 0,  ev(0, M_ADD,   0, 1, 1, 0, 0, 0, 0, 1, 0, 0)};
        vt[12] = '{5'b11010, 1, 0, 0,  ev(0, M_ADD,   0, 1, 1, 0, 0, 0, 1, 1, 0, 0)};
        vt[13] = '{5'b11011, 1, 0, 0,  ev(0, M_ADD,   0, 1, 1, 0, 0, 0, 0, 1, 0, 0)};
        vt[14] = '{5'b11101, 0, 0, 0,  ev(0, M_ADD,   0, 1, 1, 0, 0, 0, 1, 1, 0, 0)};
        vt[15] = '{5'b11101, 1, 1, 0,  ev(0, M_ADD,   0, 1, 1, 0, 0, 0, 0, 1, 0, 0)};
        vt[16] = '{5'b10010, 0, 0, 3,  ev(0, M_BYP,   0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        vt[17] = '{5'b10011, 0, 0, 0,  ev(0, M_BYP,   0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        vt[18] = '{5'b10010, 0, 0, 14, ev(0, M_BYP,   0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        vt[19] = '{5'b10011, 0, 0, 14, ev(0, M_BYP,   0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};

        // Reset state.
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_state", 14'd0);

        // Idle FETCH with no instruction stays idle.
        drive(1'b0, rop(), rb(), rb(), rb(), 1'b0);
        check("idle_fetch", 14'd0);

        foreach (vt[i]) begin
            run_instr(vt[i].op, vt[i].n, vt[i].z, vt[i].dly, vt[i].exp, term);
            if (term) do_reset();
        end

        // Store that never sees mem_ready: 15 MEM cycles then FAULT until reset.
        run_instr(5'b10011, 1'b0, 1'b0, 1000, exec_exp(5'b10011, 1'b0, 1'b0), term);
        if (!term) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_timeout_term: got=0 want=1");
        end
        do_reset();
        run_instr(5'b00001, 1'b0, 1'b0, 0, exec_exp(5'b00001, 1'b0, 1'b0), term);

        // Illegal opcode and halt both absorb further instructions.
        run_instr(5'b10110, 1'b0, 1'b0, 0, 14'd0, term);
        do_reset();
        run_instr(5'b11110, 1'b0, 1'b0, 0, 14'd0, term);
        do_reset();

        // Reset on the second MEM cycle of a load aborts the access at once.
        drive(1'b1, 5'b10010, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_accept", ev(1, M_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_decode", ev(0, M_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_exec", ev(0, M_BYP, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_mem1", ev(0, M_BYP, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("abort_mem2", ev(0, M_BYP, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_after_rst", 14'd0);
        run_instr(5'b01011, 1'b0, 1'b0, 0, exec_exp(5'b01011, 1'b0, 1'b0), term);

        // Randomized instruction stream against the opcode-level model.
        for (int i = 0; i < 120; i++) begin
            op = rop();
            n = rb();
            z = rb();
            dly = ($urandom_range(0, 6) == 0) ? int'($urandom_range(13, 16))
                                              : int'($urandom_range(0, 4));
            run_instr(op, n, z, dly, exec_exp(op, n, z), term);
            if (term) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
